image_processor_bram: RTL and testbench
=======================================

IMAGE_PROCESSOR_BRAM -- requirements
Module: image_processor_bram

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 4: pixels per row.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 4: rows per image; IMAGE_SIZE = IMAGE_WIDTH*IMAGE_HEIGHT, address width = clog2(IMAGE_SIZE), minimum 1.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to process the whole image; sampled in IDLE or DONE only.
REQ-006 operation_select  input  2  00 negative, 01 threshold, 10 brightness, 11 grayscale.
REQ-007 threshold_value  input  8  threshold for op 01.
REQ-008 brightness_value  input  8  unsigned increment for op 10.
REQ-009 done  output  1  high while in DONE state.
REQ-010 pixel_out  output  24  last processed pixel, {R[23:16],G[15:8],B[7:0]}.
REQ-011 pixel_valid_out  output  1  one-cycle pulse qualifying pixel_out.
REQ-012 SHALL provide simulation backdoor task load_pixel(index, data[23:0]) writing input memory, and function read_pixel(index) returning data[23:0] from output memory.

Function
REQ-013 SHALL hold two IMAGE_SIZE x 24-bit memories: input (in_mem) and output (out_mem); in_mem read is synchronous, 1-cycle latency.
REQ-014 FSM states IDLE, READ, PROC, DONE.
REQ-015 IDLE/DONE + start: latch operation_select, threshold_value, brightness_value; addr<=0; go READ; done<=0.
REQ-016 READ: issue in_mem read at addr; next PROC.
REQ-017 PROC: compute result, write out_mem[addr], pixel_out<=result, pixel_valid_out<=1 for one cycle; if addr==IMAGE_SIZE-1 go DONE else addr<=addr+1, go READ.
REQ-018 Timing: pixel k written on edge 2k+2 after the start-sampling edge; done high from edge 2*IMAGE_SIZE onward; held until next start or reset.
REQ-019 start while in READ/PROC SHALL be ignored; input changes mid-run SHALL not affect results (latched values used).
REQ-020 Negative: each channel 255-c.
REQ-021 Brightness: each channel min(c+brightness_value,255), 9-bit sum, saturate.
REQ-022 Gray g = (R+G+B)/3, 10-bit sum, integer truncating divide.
REQ-023 Threshold: result 24'hFFFFFF if g > threshold_value else 24'h000000 (equal -> 0).
REQ-024 Grayscale: result {g,g,g}.
REQ-025 in_mem SHALL never be modified by processing; re-running start reprocesses the same input.

Reset
REQ-026 rst: state IDLE, addr 0, done 0, pixel_valid_out 0, pixel_out 0, latched config 0.
REQ-027 Memory contents SHALL NOT be cleared by reset; reset mid-run aborts, partially written out_mem retained.

Structure
REQ-028 Package image_processor_pkg: operation code constants, FSM state enum, pixel width constant (24).
REQ-029 One combinational sub-module pixel_alu (pixel in, op, threshold, brightness -> pixel out) holding REQ-020..024; FSM and memories in top.

Verification
REQ-030 in_mem[i]={100+i,50+i,25+i}, op 00, start -> out_mem[0]=9BCDE6, out_mem[15]=8CBED7, done after 32 edges, 16 valid pulses.
REQ-031 Same load, op 10, brightness 30 -> out_mem[0]=825037; pixel {240,250,10} -> FFFF28 (saturation).
REQ-032 op 01, threshold 100: pixel {100,50,25} (g=58) -> 000000; {200,200,200} -> FFFFFF; {100,100,100} -> 000000.
REQ-033 op 11: pixel {100,50,25} -> 3A3A3A; {255,255,255} -> FFFFFF.
REQ-034 Start pulse during run and op change mid-run -> no effect, all pixels use latched op; restart from DONE reprocesses correctly.
REQ-035 rst asserted mid-run -> next edge done=0, pixel_valid_out=0, IDLE; subsequent start completes normally.

Source files
------------

// File: rtl/image_processor_pkg.sv
// Shared constants and types for the image processor: op codes, FSM states,
// latched run configuration and a saturating channel add.
package image_processor_pkg;

    localparam int PIXEL_W = 24;
    localparam int CHAN_W  = 8;
    localparam int NUM_CH  = 3;

    localparam logic [1:0] OP_NEG    = 2'b00;
    localparam logic [1:0] OP_THRESH = 2'b01;
    localparam logic [1:0] OP_BRIGHT = 2'b10;
    localparam logic [1:0] OP_GRAY   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_PROC,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [1:0]        op;
        logic [CHAN_W-1:0] thresh;
        logic [CHAN_W-1:0] bright;
    } cfg_t;

    function automatic logic [CHAN_W-1:0] sat_add(input logic [CHAN_W-1:0] a,
                                                  input logic [CHAN_W-1:0] b);
        logic [CHAN_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CHAN_W] ? {CHAN_W{1'b1}} : sum[CHAN_W-1:0];
    endfunction

endpackage

// File: rtl/image_processor_bram_pixel_alu.sv
// Combinational per-pixel transform: negative, threshold, brightness, grayscale.
module pixel_alu
    import image_processor_pkg::*;
(
    input  logic [PIXEL_W-1:0] pix_in,
    input  logic [1:0]         op,
    input  logic [CHAN_W-1:0]  thresh,
    input  logic [CHAN_W-1:0]  bright,
    output logic [PIXEL_W-1:0] pix_out
);

    logic [NUM_CH-1:0][CHAN_W-1:0] ch;
    logic [NUM_CH-1:0][CHAN_W-1:0] neg_ch;
    logic [NUM_CH-1:0][CHAN_W-1:0] brt_ch;
    logic [9:0]                    gray_sum;
    logic [9:0]                    gray_div;
    logic [CHAN_W-1:0]             gray;

    assign ch = pix_in;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign neg_ch[gi] = ~ch[gi];
            assign brt_ch[gi] = sat_add(ch[gi], bright);
        end
    endgenerate

    // 10-bit sum holds up to 765; quotient always fits in 8 bits
    assign gray_sum = {2'b00, ch[2]} + {2'b00, ch[1]} + {2'b00, ch[0]};
    assign gray_div = gray_sum / 10'd3;
    assign gray     = gray_div[CHAN_W-1:0];

    always_comb begin
        pix_out = '0;
        unique case (op)
            OP_NEG:    pix_out = neg_ch;
            OP_THRESH: pix_out = (gray > thresh) ? {PIXEL_W{1'b1}} : '0;
            OP_BRIGHT: pix_out = brt_ch;
            OP_GRAY:   pix_out = {gray, gray, gray};
            default:   pix_out = '0;
        endcase
    end

endmodule

// File: rtl/image_processor_bram.sv
// Whole-image processor: walks in_mem one pixel per READ/PROC pair, writes the
// transformed pixel to out_mem and pulses pixel_valid_out for each one.
module image_processor_bram
    import image_processor_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 4,
    parameter int IMAGE_HEIGHT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         operation_select,
    input  logic [7:0]         threshold_value,
    input  logic [7:0]         brightness_value,
    output logic               done,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               pixel_valid_out
);

    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int AW         = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMAGE_SIZE - 1);

    logic [PIXEL_W-1:0] in_mem  [IMAGE_SIZE];
    logic [PIXEL_W-1:0] out_mem [IMAGE_SIZE];

    state_t             state;
    logic [AW-1:0]      addr;
    cfg_t               cfg;
    logic [PIXEL_W-1:0] rd_q;
    logic [PIXEL_W-1:0] alu_out;

    pixel_alu u_alu (
        .pix_in  (rd_q),
        .op      (cfg.op),
        .thresh  (cfg.thresh),
        .bright  (cfg.bright),
        .pix_out (alu_out)
    );

    // Memories carry no reset so contents survive rst and map onto block RAM
    always_ff @(posedge clk) begin
        if (state == ST_READ)
            rd_q <= in_mem[addr];
        if (state == ST_PROC)
            out_mem[addr] <= alu_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            addr            <= '0;
            cfg             <= '0;
            done            <= 1'b0;
            pixel_out       <= '0;
            pixel_valid_out <= 1'b0;
        end else begin
            pixel_valid_out <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cfg   <= '{op: operation_select, thresh: threshold_value,
                                   bright: brightness_value};
                        addr  <= '0;
                        done  <= 1'b0;
                        state <= ST_READ;
                    end
                end
                ST_READ: state <= ST_PROC;
                ST_PROC: begin
                    pixel_out       <= alu_out;
                    pixel_valid_out <= 1'b1;
                    if (addr == LAST_ADDR) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= ST_READ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Simulation backdoor access to the pixel memories
    task automatic load_pixel(input int unsigned index, input logic [PIXEL_W-1:0] data);
        in_mem[AW'(index)] = data;
    endtask

    function automatic logic [PIXEL_W-1:0] read_pixel(input int unsigned index);
        return out_mem[AW'(index)];
    endfunction

endmodule

// File: tb/tb_image_processor_bram.sv
// Directed bench for image_processor_bram: hand-computed pixel results, run
// timing, mid-run disturbance and mid-run reset.
module tb_image_processor_bram;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  operation_select;
    logic [7:0]  threshold_value;
    logic [7:0]  brightness_value;
    logic        done;
    logic [23:0] pixel_out;
    logic        pixel_valid_out;

    int total = 0;
    int bad   = 0;

    image_processor_bram #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .operation_select (operation_select),
        .threshold_value  (threshold_value),
        .brightness_value (brightness_value),
        .done             (done),
        .pixel_out        (pixel_out),
        .pixel_valid_out  (pixel_valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pat(input int i);
        return {8'(100 + i), 8'(50 + i), 8'(25 + i)};
    endfunction

    task automatic load_pattern();
        for (int i = 0; i < 16; i++) dut.load_pixel(i, pat(i));
    endtask

    // Start a run and count edges until done; optionally disturb inputs mid-run.
    task automatic run_op(input logic [1:0] op, input logic [7:0] thr, input logic [7:0] bri,
                          input bit disturb, output int cycles, output int pulses,
                          output logic [23:0] last_pix);
        @(negedge clk);
        operation_select = op;
        threshold_value  = thr;
        brightness_value = bri;
        start            = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles   = -1;
        pulses   = 0;
        last_pix = '0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (pixel_valid_out) begin
                pulses++;
                last_pix = pixel_out;
            end
            if (done) begin
                cycles = c;
                break;
            end
            if (disturb && c == 5) begin
                start            = 1'b1;
                operation_select = 2'b10;
                brightness_value = 8'd77;
            end
            if (disturb && c == 6) start = 1'b0;
        end
    endtask

    int          cyc;
    int          np;
    logic [23:0] lp;

    initial begin
        rst = 1'b1; start = 1'b0;
        operation_select = 2'b00; threshold_value = 8'd0; brightness_value = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, pixel_valid_out}, 32'd0);
        chk("rst_pix", {8'd0, pixel_out}, 32'd0);
        rst = 1'b0;

        // negative
        load_pattern();
        run_op(2'b00, 8'd0, 8'd0, 1'b0, cyc, np, lp);
        chk("neg_cycles", 32'(cyc), 32'd32);
        chk("neg_pulses", 32'(np), 32'd16);
        chk("neg_last_pix", {8'd0, lp}, 32'h8CBED7);
        chk("neg_out0", {8'd0, dut.read_pixel(0)}, 32'h9BCDE6);
        chk("neg_out15", {8'd0, dut.read_pixel(15)}, 32'h8CBED7);
        repeat (3) @(posedge clk);
        #1 chk("done_held", {31'd0, done}, 32'd1);

        // brightness with a saturating pixel
        dut.load_pixel(5, {8'd240, 8'd250, 8'd10});
        run_op(2'b10, 8'd0, 8'd30, 1'b0, cyc, np, lp);
        chk("bri_pulses", 32'(np), 32'd16);
        chk("bri_out0", {8'd0, dut.read_pixel(0)}, 32'h825037);
        chk("bri_out5_sat", {8'd0, dut.read_pixel(5)}, 32'hFFFF28);
        chk("bri_out15", {8'd0, dut.read_pixel(15)}, 32'h915F46);

        // threshold, including the equal case
        dut.load_pixel(1, {8'd200, 8'd200, 8'd200});
        dut.load_pixel(2, {8'd100, 8'd100, 8'd100});
        run_op(2'b01, 8'd100, 8'd0, 1'b0, cyc, np, lp);
        chk("thr_out0", {8'd0, dut.read_pixel(0)}, 32'h000000);
        chk("thr_out1", {8'd0, dut.read_pixel(1)}, 32'hFFFFFF);
        chk("thr_out2_eq", {8'd0, dut.read_pixel(2)}, 32'h000000);

        // grayscale
        dut.load_pixel(3, {8'd255, 8'd255, 8'd255});
        run_op(2'b11, 8'd0, 8'd0, 1'b0, cyc, np, lp);
        chk("gray_out0", {8'd0, dut.read_pixel(0)}, 32'h3A3A3A);
        chk("gray_out1", {8'd0, dut.read_pixel(1)}, 32'hC8C8C8);
        chk("gray_out3", {8'd0, dut.read_pixel(3)}, 32'hFFFFFF);

        // start and op change mid-run are ignored
        load_pattern();
        run_op(2'b00, 8'd0, 8'd0, 1'b1, cyc, np, lp);
        chk("dist_cycles", 32'(cyc), 32'd32);
        chk("dist_pulses", 32'(np), 32'd16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("dist_out%0d", i), {8'd0, dut.read_pixel(i)},
                {8'd0, 8'(155 - i), 8'(205 - i), 8'(230 - i)});

        // restart from DONE reprocesses the untouched input
        run_op(2'b10, 8'd0, 8'd30, 1'b0, cyc, np, lp);
        chk("rerun_cycles", 32'(cyc), 32'd32);
        chk("rerun_out0", {8'd0, dut.read_pixel(0)}, 32'h825037);
        chk("rerun_out10", {8'd0, dut.read_pixel(10)}, 32'h8C5A41);

        // reset mid-run: pixels 0..2 rewritten, rest retained
        @(negedge clk);
        operation_select = 2'b11;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_valid", {31'd0, pixel_valid_out}, 32'd0);
        chk("mrst_pix", {8'd0, pixel_out}, 32'd0);
        rst = 1'b0;
        chk("mrst_out0", {8'd0, dut.read_pixel(0)}, 32'h3A3A3A);
        chk("mrst_out10", {8'd0, dut.read_pixel(10)}, 32'h8C5A41);
        repeat (3) @(posedge clk);
        #1 chk("mrst_idle", {31'd0, done}, 32'd0);

        // normal run after reset
        run_op(2'b11, 8'd0, 8'd0, 1'b0, cyc, np, lp);
        chk("post_cycles", 32'(cyc), 32'd32);
        chk("post_pulses", 32'(np), 32'd16);
        chk("post_out10", {8'd0, dut.read_pixel(10)}, 32'h444444);
        chk("post_out15", {8'd0, dut.read_pixel(15)}, 32'h494949);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
